// File: rtl/dcache_pkg.sv
// Shared types and default widths for the dcache write-through buffer.
package dcache_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned LINE_BYTES_DEF = 64;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrBusy,
    StRdBusy
  } wbuf_state_t;

endpackage

// File: rtl/wbuf_line_match.sv
// Compares a read address against every valid buffered write at cache-line granularity.
module wbuf_line_match #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned DEPTH      = 8
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic                         o_conflict
);

  // Clears the byte-in-line offset bits so only the line address is compared.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  logic [DEPTH-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_valid[i] && ((i_addr[i] & LINE_MASK) == (i_rd_addr & LINE_MASK));
    end
  end

  assign o_conflict = |w_hit;

endmodule

// File: rtl/dcache_wbuf.sv
// Write-through buffer between the dcache and memory: queues writes, serves one line-fill read,
// and keeps a read behind any buffered write to the same line.
module dcache_wbuf
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     up_req,
  input  logic [ADDR_W-1:0]        up_addr,
  input  logic                     up_write,
  input  logic [DATA_W-1:0]        up_wdata,
  output logic                     up_ack,
  output logic [DATA_W-1:0]        up_rdata,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_full,
  output logic                     wb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [PTR_W:0]               r_count;
  wbuf_state_t                  r_state;
  wbuf_state_t                  w_state_d;
  logic                         r_rd_valid;
  logic                         r_rd_hazard;
  logic [ADDR_W-1:0]            r_rd_addr;
  logic                         r_up_ack;
  logic [DATA_W-1:0]            r_up_rdata;
  logic                         r_mem_req;
  logic [ADDR_W-1:0]            r_mem_addr;
  logic                         r_mem_write;
  logic [DATA_W-1:0]            r_mem_wdata;

  logic             w_full;
  logic             w_empty;
  logic             w_mem_ack;
  logic             w_accept;
  logic             w_push;
  logic             w_rd_latch;
  logic             w_pop;
  logic             w_rd_done;
  logic             w_issue_wr;
  logic             w_issue_rd;
  logic             w_conflict;
  logic             w_hazard;
  logic [DEPTH-1:0] w_valid;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_mem_ack  = mem_ack & r_mem_req;
  assign w_accept   = up_req & ~r_up_ack & ~r_rd_valid;
  assign w_push     = w_accept & up_write & (~w_full | w_pop);
  assign w_rd_latch = w_accept & ~up_write;
  // Once a read has seen a hazard it waits for the whole buffer to drain, keeping older
  // writes ordered ahead of it.
  assign w_hazard   = (w_conflict | r_rd_hazard) & ~w_empty;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
    end
  end

  wbuf_line_match #(
    .ADDR_W     (ADDR_W),
    .LINE_BYTES (LINE_BYTES),
    .DEPTH      (DEPTH)
  ) u_line_match (
    .i_valid    (w_valid),
    .i_addr     (r_addr),
    .i_rd_addr  (r_rd_addr),
    .o_conflict (w_conflict)
  );

  always_comb begin
    w_state_d  = r_state;
    w_issue_wr = 1'b0;
    w_issue_rd = 1'b0;
    w_pop      = 1'b0;
    w_rd_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_rd_valid && !w_hazard) begin
          w_issue_rd = 1'b1;
          w_state_d  = StRdBusy;
        end else if (!w_empty) begin
          w_issue_wr = 1'b1;
          w_state_d  = StWrBusy;
        end
      end
      StWrBusy: begin
        if (w_mem_ack) begin
          w_pop     = 1'b1;
          w_state_d = StIdle;
        end
      end
      StRdBusy: begin
        if (w_mem_ack) begin
          w_rd_done = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= up_addr;
      r_data[r_wr_ptr] <= up_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_hazard <= 1'b0;
      r_rd_addr   <= '0;
      r_up_ack    <= 1'b0;
      r_up_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_up_ack <= w_push | w_rd_done;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

      if (w_rd_latch) begin
        r_rd_valid <= 1'b1;
        r_rd_addr  <= up_addr;
      end else if (w_rd_done) begin
        r_rd_valid <= 1'b0;
      end

      if (w_issue_rd) begin
        r_rd_hazard <= 1'b0;
      end else if (r_rd_valid && w_conflict) begin
        r_rd_hazard <= 1'b1;
      end

      if (w_rd_done) r_up_rdata <= mem_rdata;

      if (w_issue_wr) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= r_addr[r_rd_ptr];
        r_mem_write <= 1'b1;
        r_mem_wdata <= r_data[r_rd_ptr];
      end else if (w_issue_rd) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= r_rd_addr;
        r_mem_write <= 1'b0;
        r_mem_wdata <= '0;
      end else if (w_pop || w_rd_done) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign up_ack    = r_up_ack;
  assign up_rdata  = r_up_rdata;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_write = r_mem_write;
  assign mem_wdata = r_mem_wdata;
  assign wb_count  = r_count;
  assign wb_full   = w_full;
  assign wb_empty  = w_empty;

endmodule

// File: tb/tb_dcache_wbuf.sv
// Scoreboard bench for dcache_wbuf: expected memory transactions and up_ack responses are queued
// by the stimulus and checked by a memory model and an ack monitor.
module tb_dcache_wbuf;
  import dcache_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 8;
  localparam int          BIG   = 1000000;

  typedef struct {
    logic        wr;
    wbuf_entry_t e;
  } mem_exp_t;

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
  } ack_exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    up_req = 1'b0;
  logic [AW-1:0]           up_addr = '0;
  logic                    up_write = 1'b0;
  logic [DW-1:0]           up_wdata = '0;
  logic                    up_ack;
  logic [DW-1:0]           up_rdata;
  logic                    mem_req;
  logic [AW-1:0]           mem_addr;
  logic                    mem_write;
  logic [DW-1:0]           mem_wdata;
  logic                    mem_ack;
  logic [DW-1:0]           mem_rdata;
  logic [$clog2(DEPTH):0]  wb_count;
  logic                    wb_full;
  logic                    wb_empty;

  mem_exp_t exp_mem_q[$];
  ack_exp_t exp_ack_q[$];
  int       checks = 0;
  int       errors = 0;
  logic     mem_en = 1'b1;
  logic     rand_delay = 1'b0;
  logic     force_ack = 1'b0;
  int       ack_limit = BIG;
  int       acks_done = 0;

  always #5 clk = ~clk;

  dcache_wbuf #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LINE_BYTES (64),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_req    (up_req),
    .up_addr   (up_addr),
    .up_write  (up_write),
    .up_wdata  (up_wdata),
    .up_ack    (up_ack),
    .up_rdata  (up_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_count  (wb_count),
    .wb_full   (wb_full),
    .wb_empty  (wb_empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acks each request after a delay and scores it against exp_mem_q.
  initial begin : mem_model
    int            wcnt;
    int            delay;
    logic [AW-1:0] seen;
    mem_exp_t      ex;
    wcnt      = 0;
    delay     = 0;
    seen      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        mem_ack = force_ack;
        wcnt    = 0;
      end else if (mem_ack || !rst_n) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_req) begin
        if (wcnt == 0) begin
          seen  = mem_addr;
          delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
        end else begin
          check("mem_addr_stable", mem_addr, seen);
        end
        if (wcnt >= delay && acks_done < ack_limit) begin
          check("mem_txn_expected", 64'(exp_mem_q.size() != 0), 1);
          if (exp_mem_q.size() != 0) begin
            ex = exp_mem_q.pop_front();
            check("mem_addr", mem_addr, ex.e.addr);
            check("mem_write", mem_write, ex.wr);
            if (ex.wr) check("mem_wdata", mem_wdata, ex.e.data);
          end
          mem_rdata = 64'hCAFE_0000_0000_0000 | 64'(mem_addr);
          mem_ack   = 1'b1;
          acks_done++;
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin : ack_mon
    ack_exp_t ea;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && up_ack) begin
        check("up_ack_expected", 64'(exp_ack_q.size() != 0), 1);
        if (exp_ack_q.size() != 0) begin
          ea = exp_ack_q.pop_front();
          if (ea.rd) check("up_rdata", up_rdata, ea.data);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic exp_mem(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_exp_t ex;
    ex.wr     = wr;
    ex.e.addr = a;
    ex.e.data = d;
    exp_mem_q.push_back(ex);
  endtask

  task automatic start_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] rd_exp);
    ack_exp_t ea;
    ea.rd   = !wr;
    ea.data = rd_exp;
    exp_ack_q.push_back(ea);
    up_req   = 1'b1;
    up_write = wr;
    up_addr  = a;
    up_wdata = d;
  endtask

  task automatic wait_ack(input string name, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!up_ack && cyc < max_cyc);
    check({name, "_ack_seen"}, up_ack, 1);
    up_req = 1'b0;
  endtask

  task automatic do_wr(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int cyc;
    start_req(1'b1, a, d, '0);
    wait_ack(name, 50, cyc);
  endtask

  task automatic wait_empty(input string name, input int max_cyc);
    int cyc;
    cyc = 0;
    while (!(wb_empty && !mem_req) && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_drained"}, 64'(wb_empty && !mem_req), 1);
  endtask

  task automatic single_write_test(input string name);
    int cyc;
    exp_mem(1'b1, 32'h1000, 64'hAA);
    start_req(1'b1, 32'h1000, 64'hAA, '0);
    wait_ack(name, 10, cyc);
    check({name, "_ack_latency"}, 64'(cyc), 1);
    check({name, "_count1"}, 64'(wb_count), 1);
    @(posedge clk);
    #1;
    check({name, "_mem_req"}, mem_req, 1);
    check({name, "_mem_write"}, mem_write, 1);
    check({name, "_mem_addr"}, mem_addr, 32'h1000);
    check({name, "_mem_wdata"}, mem_wdata, 64'hAA);
    wait_empty(name, 20);
    check({name, "_count0"}, 64'(wb_count), 0);
  endtask

  initial begin : stim
    int cyc;
    #2;
    check("rst_up_ack", up_ack, 0);
    check("rst_up_rdata", up_rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_count", 64'(wb_count), 0);
    check("rst_empty", wb_empty, 1);
    check("rst_full", wb_full, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single_write_test("t37");

    // Fill with memory stalled; ninth write must wait for a pop.
    ack_limit = acks_done;
    for (int i = 0; i < 9; i++) exp_mem(1'b1, 32'h6000 + 32'(i) * 32'h40, 64'h3800 + 64'(i));
    for (int i = 0; i < 8; i++) do_wr("t38_fill", 32'h6000 + 32'(i) * 32'h40, 64'h3800 + 64'(i));
    check("t38_full", wb_full, 1);
    check("t38_count8", 64'(wb_count), 8);
    start_req(1'b1, 32'h6200, 64'h3808, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t38_no_ack_when_full", up_ack, 0);
    end
    ack_limit = acks_done + 1;
    wait_ack("t38_ninth", 5, cyc);
    check("t38_count_after_swap", 64'(wb_count), 8);
    ack_limit = BIG;
    wait_empty("t38", 200);

    // Same-line read behind two buffered writes.
    ack_limit = acks_done;
    exp_mem(1'b1, 32'h2008, 64'h11);
    exp_mem(1'b1, 32'h5000, 64'h22);
    exp_mem(1'b0, 32'h2000, '0);
    do_wr("t39_w0", 32'h2008, 64'h11);
    do_wr("t39_w1", 32'h5000, 64'h22);
    start_req(1'b0, 32'h2000, '0, 64'hCAFE_0000_0000_2000);
    repeat (3) @(posedge clk);
    #1;
    check("t39_head_held", mem_addr, 32'h2008);
    ack_limit = BIG;
    wait_ack("t39_rd", 60, cyc);
    check("t39_rdata", up_rdata, 64'hCAFE_0000_0000_2000);
    @(posedge clk);
    #1;
    check("t39_rdata_hold", up_rdata, 64'hCAFE_0000_0000_2000);
    wait_empty("t39", 50);

    // Different-line read bypasses the buffered write.
    ack_limit = acks_done;
    exp_mem(1'b1, 32'h4000, 64'h33);
    exp_mem(1'b0, 32'h3000, '0);
    exp_mem(1'b1, 32'h5000, 64'h44);
    do_wr("t40_w0", 32'h4000, 64'h33);
    do_wr("t40_w1", 32'h5000, 64'h44);
    start_req(1'b0, 32'h3000, '0, 64'hCAFE_0000_0000_3000);
    repeat (2) @(posedge clk);
    #1;
    ack_limit = BIG;
    wait_ack("t40_rd", 60, cyc);
    check("t40_write_left", 64'(wb_count), 1);
    wait_empty("t40", 50);

    // Pointer wrap with random memory latency.
    rand_delay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_mem(1'b1, 32'h8000 + 32'(i) * 32'h40, 64'h100 + 64'(i));
      do_wr("t41", 32'h8000 + 32'(i) * 32'h40, 64'h100 + 64'(i));
    end
    wait_empty("t41", 400);
    check("t41_empty", wb_empty, 1);
    check("t41_all_seen", 64'(exp_mem_q.size()), 0);
    rand_delay = 1'b0;

    // Reset in the middle of a write burst.
    ack_limit = acks_done;
    do_wr("t42_w0", 32'hA000, 64'h1);
    do_wr("t42_w1", 32'hA040, 64'h2);
    do_wr("t42_w2", 32'hA080, 64'h3);
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    check("t42_busy", mem_req, 1);
    check("t42_count3", 64'(wb_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t42_up_ack", up_ack, 0);
    check("t42_up_rdata", up_rdata, 0);
    check("t42_mem_req", mem_req, 0);
    check("t42_mem_addr", mem_addr, 0);
    check("t42_mem_write", mem_write, 0);
    check("t42_mem_wdata", mem_wdata, 0);
    check("t42_count", 64'(wb_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t42_late_ack_count", 64'(wb_count), 0);
    check("t42_late_ack_req", mem_req, 0);
    check("t42_late_ack_up", up_ack, 0);
    mem_en    = 1'b1;
    ack_limit = BIG;
    single_write_test("t42_post");

    check("end_mem_q_empty", 64'(exp_mem_q.size()), 0);
    check("end_ack_q_empty", 64'(exp_ack_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
